// File: rtl/pipe_rc_adder.sv
// pipe_rc_adder: pipelined ripple-carry adder.
// A WIDTH-bit add is cut into STAGES = WIDTH/SEG segments, one segment per
// pipeline stage. The carry between segments is registered, upper operand
// segments are skewed forward, and finished low sum bits travel with the data.
// A single global enable stalls the whole pipe when the output is blocked.

// One SEG-bit ripple-carry chain; this is the whole critical path of a stage.
module pipe_rc_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    logic [SEG:0] c;

    // Bit-serial full-adder chain, LSB to MSB.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[SEG];
endmodule

module pipe_rc_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int STAGES = WIDTH / SEG;

    // The pipe moves as one unit: it advances unless a result is stuck at
    // the output. Bubbles are never squeezed out.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO = k * SEG;

        // Stage inputs. w_* holds finished sum bits below LO and operand a
        // at/above LO; b_i holds the operand b bits still to be added.
        logic                vld_i;
        logic                cy_i;
        logic [WIDTH-1:0]    w_i;
        logic [WIDTH-LO-1:0] b_i;

        logic [SEG-1:0]      s_seg;
        logic                co_seg;
        logic [WIDTH-1:0]    w_n;

        logic                vld_q;
        logic                cy_q;
        logic [WIDTH-1:0]    w_q;

        if (k == 0) begin : g_src
            assign vld_i = in_valid;
            assign cy_i  = c_in;
            assign w_i   = a;
            assign b_i   = b;
        end else begin : g_src
            assign vld_i = stg[k-1].vld_q;
            assign cy_i  = stg[k-1].cy_q;
            assign w_i   = stg[k-1].w_q;
            assign b_i   = stg[k-1].g_skew.b_q;
        end

        pipe_rc_seg #(.SEG(SEG)) u_seg (
            .a  (w_i[LO +: SEG]),
            .b  (b_i[SEG-1:0]),
            .ci (cy_i),
            .s  (s_seg),
            .co (co_seg)
        );

        // Replace this stage's a segment with its finished sum segment.
        always_comb begin
            w_n            = w_i;
            w_n[LO +: SEG] = s_seg;
        end

        // Stage register: valid, merged sum/operand word and segment carry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                w_q   <= '0;
                cy_q  <= 1'b0;
            end else if (en) begin
                vld_q <= vld_i;
                w_q   <= w_n;
                cy_q  <= co_seg;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            // Remaining b segments, shrinking by one segment per stage.
            logic [WIDTH-LO-SEG-1:0] b_q;

            // Skew the untouched b segments forward with their carry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  b_q <= '0;
                else if (en) b_q <= b_i[WIDTH-LO-1:SEG];
            end
        end else begin : g_last
            logic ov_q;

            // Carry into the MSB is recovered as a^b^s at that bit; signed
            // overflow is that carry XOR the carry out of the MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  ov_q <= 1'b0;
                else if (en) ov_q <= w_i[WIDTH-1] ^ b_i[SEG-1] ^ s_seg[SEG-1] ^ co_seg;
            end
        end
    end

    assign out_valid = stg[STAGES-1].vld_q;
    assign sum       = stg[STAGES-1].w_q;
    assign c_out     = stg[STAGES-1].cy_q;
    assign ovf       = stg[STAGES-1].g_last.ov_q;
endmodule
